psum_accum_sfu: RTL

Post-array special-function unit that drains partial-sum vectors from the output FIFO. It accumulates them across `kij` kernel passes in an internal buffer of `nij` vectors, applies ReLU plus signed saturation, and writes the finished activations to output SRAM. It sits directly downstream of the output FIFO and consumes its `out`/`o_valid`/`rd` handshake.

---
 rtl/psum_accum_sfu_pkg.sv | 7 +
 rtl/psum_accum_sfu_relu_sat.sv | 9 +
 rtl/psum_accum_sfu.sv | 85 ++++++++
 3 files changed

// File: rtl/psum_accum_sfu_pkg.sv
// psum_accum_sfu_pkg: shared state encoding, accumulator width and saturation bound
package psum_accum_sfu_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, CAP, DRAIN, DONE} state_t;
  localparam int PSUM_BW = 16;
  localparam int ACC_BW = PSUM_BW + 4;
  localparam logic signed [ACC_BW-1:0] SAT_MAX = ACC_BW'(2 ** (PSUM_BW - 1) - 1);
endpackage

// File: rtl/psum_accum_sfu_relu_sat.sv
// relu_sat: one-lane ReLU clamp followed by signed saturation to the psum width
module relu_sat
  import psum_accum_sfu_pkg::*;
(
  input  logic signed [ACC_BW-1:0]  acc,
  output logic        [PSUM_BW-1:0] act
);
  always_comb act = acc[ACC_BW-1] ? '0 : (acc > SAT_MAX) ? SAT_MAX[PSUM_BW-1:0] : acc[PSUM_BW-1:0];
endmodule

// File: rtl/psum_accum_sfu.sv
// psum_accum_sfu: accumulates FIFO psum vectors over kij passes, then drains relu_sat results to SRAM
module psum_accum_sfu
  import psum_accum_sfu_pkg::*;
#(
  parameter int col = 8,
  parameter int psum_bw = PSUM_BW,
  parameter int nij = 16,
  parameter int kij = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       ofifo_valid,
  input  logic [col*psum_bw-1:0]     ofifo_out,
  output logic                       ofifo_rd,
  output logic                       out_wr,
  output logic [$clog2(nij)-1:0]     out_addr,
  output logic [col*psum_bw-1:0]     out_data,
  output logic                       busy,
  output logic                       done
);
  localparam int acc_bw = psum_bw + 4;
  localparam int aw = $clog2(nij);
  localparam int kw = $clog2(kij + 1);
  state_t state;
  logic [aw-1:0] n, d;
  logic [kw-1:0] k;
  logic signed [acc_bw-1:0] acc_buf [nij][col];
  logic [col*psum_bw-1:0] act;
  always_comb ofifo_rd = (state == REQ) & ofifo_valid;
  for (genvar i = 0; i < col; i++) begin : g_lane
    relu_sat u_rs (.acc(acc_buf[d][i]), .act(act[psum_bw*i +: psum_bw]));
  end
  // buffer is deliberately left unreset: pass 0 overwrites every entry
  always_ff @(posedge clk)
    if (!reset && state == CAP)
      for (int i = 0; i < col; i++)
        acc_buf[n][i] <= (k == '0 ? '0 : acc_buf[n][i]) + acc_bw'(signed'(ofifo_out[psum_bw*i +: psum_bw]));
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      out_wr <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      n <= '0;
      k <= '0;
      d <= '0;
    end else begin
      out_wr <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          n <= '0;
          k <= '0;
          d <= '0;
          if (start && !busy) begin
            state <= REQ;
            busy <= 1'b1;
          end
        end
        REQ: state <= ofifo_valid ? WAIT : REQ;
        WAIT: state <= CAP;
        CAP: begin
          n <= (n == aw'(nij - 1)) ? '0 : n + 1'b1;
          k <= (n == aw'(nij - 1)) ? k + 1'b1 : k;
          state <= (n == aw'(nij - 1) && k == kw'(kij - 1)) ? DRAIN : REQ;
        end
        DRAIN: begin
          out_wr <= 1'b1;
          out_addr <= d;
          out_data <= act;
          d <= d + 1'b1;
          state <= (d == aw'(nij - 1)) ? DONE : DRAIN;
        end
        DONE: begin
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
